crc32_stream_engine: RTL
========================

// Module: crc32_stream_engine
// PURPOSE
//  Parametrised Ethernet CRC-32 engine for the MAC TX/RX datapaths. Consumes a framed
//  byte stream of DATA_BYTES bytes per beat, with a byte-valid mask on the last beat.
//  Emits the final CRC through a ready/valid result port. On RX it also flags a good
//  FCS via the CRC-32 residue check.
// PARAMETERS
//  DATA_BYTES  1            bytes per beat: 1, 2, 4 or 8
//  POLY        32'h04C11DB7 generator polynomial, normal form
//  INIT        32'hFFFFFFFF register preset at frame start
//  XOR_OUT     32'hFFFFFFFF final XOR applied to the result
//  RESIDUE     32'h2144DF1C post-XOR value of a frame that includes a correct FCS
// PORTS
//  clk             in   1              single clock, rising edge
//  rst             in   1              asynchronous, active-high reset
//  s_valid         in   1              input beat valid
//  s_ready         out  1              input beat accepted when s_valid & s_ready
//  s_data          in   8*DATA_BYTES   lane 0 = bits[7:0] = first byte on the wire
//  s_keep          in   DATA_BYTES     byte valid mask, contiguous from lane 0
//  s_first         in   1              first beat of frame
//  s_last          in   1              last beat of frame
//  crc_valid       out  1              result valid
//  crc_ready       in   1              result consumed when crc_valid & crc_ready
//  crc_value       out  32             final CRC, reflected then XOR_OUT; LSB byte is sent first
//  crc_residue_ok  out  1              crc_value == RESIDUE; qualified by crc_valid
// BEHAVIOUR
//  - Reflected (LSB-first) CRC. All kept bytes of a beat are folded in one cycle by an
//    unrolled per-byte update. Lane i is folded before lane i+1.
//  - States:
//      IDLE  -> ACCUM  on an accepted beat with s_first & !s_last.
//      ACCUM -> IDLE   on an accepted beat with s_last.
//      ACCUM -> ACCUM  on an accepted beat with s_first & !s_last: frame restarts from INIT,
//                      prior bytes are discarded.
//  - An accepted beat with both s_first and s_last is a single-beat frame. Allowed in either state.
//  - An accepted beat in IDLE without s_first is consumed and ignored; the register is untouched.
//  - s_keep rules:
//      non-last beats must carry all ones; any zero lane is not folded.
//      last beat: only lanes with keep=1 are folded.
//      keep==0 on the last beat closes the frame over the prior bytes only.
//  - Latency: crc_valid rises on the cycle after the accepting edge of the s_last beat.
//  - crc_value and crc_residue_ok hold stable while crc_valid & !crc_ready.
//  - s_ready = !crc_valid | crc_ready. This gives a one-deep result buffer, back-to-back
//    frames run at full rate, and a new last beat may be accepted on the same edge the
//    old result is consumed.
//  - Reset, asynchronous at any time including mid-frame:
//      state=IDLE, crc register=INIT, crc_valid=0, crc_value=0, crc_residue_ok=0.
//      The open frame is abandoned; s_ready reads 1 once rst deasserts.
// CONFIGURATION
//  CRC_STATS_EN defined:
//    Adds outputs frame_cnt[15:0] and err_cnt[15:0], both reset to 0 and saturating at 16'hFFFF.
//    frame_cnt increments on each result handshake.
//    err_cnt increments on each result handshake with crc_residue_ok=0.
//    Both clear synchronously on input stats_clr (1 bit); clear wins over a same-cycle increment.
//  CRC_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. DATA_BYTES=1, "123456789" (31..39), s_last on 39
//     -> crc_valid the next cycle, crc_value=32'hCBF43926.
//  2. DATA_BYTES=4, beats 34333231 (keep F), 38373635 (keep F), 00000039 (keep 1, last)
//     -> crc_value=32'hCBF43926.
//  3. "123456789" followed by 26 39 F4 CB as data
//     -> crc_value=32'h2144DF1C, crc_residue_ok=1; flip one data bit -> crc_residue_ok=0.
//  4. crc_ready held low for 5 cycles after the result
//     -> s_ready=0 and crc_value stable throughout; back-to-back frames produce no lost beats.
//  5. s_first reissued mid-frame, then "123456789"
//     -> 32'hCBF43926. rst pulsed mid-frame -> all outputs at reset values; the next frame is correct.
//  6. CRC_STATS_EN: 3 frames, 1 corrupted -> frame_cnt=3, err_cnt=1; stats_clr -> both 0.

Source files
------------

// File: rtl/crc32_stream_engine_if.sv
// Stream-in / result-out bundle for crc32_stream_engine.
// The master side is the byte-stream source and result sink; the slave side is the engine.
interface crc32_stream_engine_if #(
    parameter int unsigned DATA_BYTES = 1
);
    logic                    s_valid;
    logic                    s_ready;
    logic [8*DATA_BYTES-1:0] s_data;
    logic [DATA_BYTES-1:0]   s_keep;
    logic                    s_first;
    logic                    s_last;
    logic                    crc_valid;
    logic                    crc_ready;
    logic [31:0]             crc_value;
    logic                    crc_residue_ok;

    modport master (
        output s_valid, s_data, s_keep, s_first, s_last, crc_ready,
        input  s_ready, crc_valid, crc_value, crc_residue_ok
    );

    modport slave (
        input  s_valid, s_data, s_keep, s_first, s_last, crc_ready,
        output s_ready, crc_valid, crc_value, crc_residue_ok
    );
endinterface

// File: rtl/crc32_stream_engine.sv
// Reflected Ethernet CRC-32 over a framed multi-byte stream, with a one-deep result buffer.
// Define CRC_STATS_EN to add the frame_cnt/err_cnt statistics counters and stats_clr.
module crc32_stream_engine #(
    parameter int unsigned DATA_BYTES = 1,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE    = 32'h2144DF1C
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef CRC_STATS_EN
    input  logic                        stats_clr,
    output logic [15:0]                 frame_cnt,
    output logic [15:0]                 err_cnt,
`endif
    crc32_stream_engine_if.slave        bus
);

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    localparam logic [31:0] RPOLY = reflect32(POLY);

    function automatic logic [31:0] fold_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ RPOLY) : (r >> 1);
        return r;
    endfunction

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e      state_q;
    logic [31:0] crc_q;
    logic        valid_q;
    logic [31:0] value_q;
    logic        ok_q;

    logic        accept;
    logic        active;
    logic [31:0] folded;
    logic [31:0] result;

    assign bus.s_ready        = !valid_q || bus.crc_ready;
    assign bus.crc_valid      = valid_q;
    assign bus.crc_value      = value_q;
    assign bus.crc_residue_ok = ok_q;

    // s_first always restarts from INIT, discarding any open frame.
    always_comb begin
        accept = bus.s_valid && bus.s_ready;
        active = bus.s_first || (state_q == StAccum);
        folded = bus.s_first ? INIT : crc_q;
        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (bus.s_keep[i]) folded = fold_byte(folded, bus.s_data[8*i +: 8]);
        end
        result = folded ^ XOR_OUT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            crc_q   <= INIT;
            valid_q <= 1'b0;
            value_q <= 32'h0;
            ok_q    <= 1'b0;
        end else begin
            if (valid_q && bus.crc_ready) valid_q <= 1'b0;
            if (accept && active) begin
                if (bus.s_last) begin
                    state_q <= StIdle;
                    crc_q   <= INIT;
                    valid_q <= 1'b1;
                    value_q <= result;
                    ok_q    <= (result == RESIDUE);
                end else begin
                    state_q <= StAccum;
                    crc_q   <= folded;
                end
            end
        end
    end

`ifdef CRC_STATS_EN
    logic handshake;
    assign handshake = valid_q && bus.crc_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'h0;
            err_cnt   <= 16'h0;
        end else if (stats_clr) begin
            frame_cnt <= 16'h0;
            err_cnt   <= 16'h0;
        end else if (handshake) begin
            if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'h1;
            if (!ok_q && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'h1;
        end
    end
`endif

endmodule
